// File: rtl/decoder_nto2n_seq.sv
// Registered binary-to-one-hot decoder with latched select, auto-scan and
// single-cycle strobe modes. All outputs come straight from flops.
module decoder_nto2n_seq #(
  parameter int SEL_W      = 3,
  parameter int NUM_OUT    = 8,
  parameter int SCAN_DIV   = 4,
  parameter int ACTIVE_LOW = 0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               en,
  input  logic [1:0]         mode,
  input  logic [SEL_W-1:0]   sel,
  input  logic               load,
  output logic [NUM_OUT-1:0] m,
  output logic [SEL_W-1:0]   idx,
  output logic               valid,
  output logic               wrap,
  output logic               err
);

  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,
    MODE_DIRECT = 2'b01,
    MODE_SCAN   = 2'b10,
    MODE_STROBE = 2'b11
  } mode_e;

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [SEL_W-1:0]   IDX_LAST = SEL_W'(NUM_OUT - 1);
  localparam logic [NUM_OUT-1:0] POL_MASK = (ACTIVE_LOW != 0) ? {NUM_OUT{1'b1}} : '0;

  mode_e              mode_q, mode_n;
  logic [DIV_W-1:0]   div_q, div_n;
  logic [SEL_W-1:0]   idx_q, idx_n;
  logic               act_q, act_n;
  logic               wrap_q, wrap_n;
  logic               err_q, err_n;
  logic [NUM_OUT-1:0] m_q, m_n;
  logic [NUM_OUT-1:0] hot_n;
  logic               legal, chg;

  always_comb begin
    mode_n = mode_e'(mode);
    chg    = (mode_n != mode_q);
    legal  = ({1'b0, sel} < (SEL_W+1)'(NUM_OUT));
    idx_n  = idx_q;
    act_n  = act_q;
    div_n  = '0;
    wrap_n = 1'b0;
    err_n  = 1'b0;
    case (mode_n)
      MODE_OFF: begin
        act_n = 1'b0;
      end
      MODE_DIRECT: begin
        // Entering DIRECT without a load shows nothing until a select is latched.
        if (load) begin
          if (legal) begin
            idx_n = sel;
            act_n = 1'b1;
          end else begin
            act_n = 1'b0;
            err_n = 1'b1;
          end
        end else if (chg) begin
          act_n = 1'b0;
        end
      end
      MODE_SCAN: begin
        act_n = 1'b1;
        if (load && legal) begin
          idx_n = sel;
        end else begin
          err_n = load;
          // The entry edge only restarts the divider; stepping begins after it.
          if (!chg) begin
            if (div_q == DIV_LAST) begin
              if (idx_q == IDX_LAST) begin
                idx_n  = '0;
                wrap_n = 1'b1;
              end else begin
                idx_n = idx_q + SEL_W'(1);
              end
            end else begin
              div_n = div_q + DIV_W'(1);
            end
          end
        end
      end
      MODE_STROBE: begin
        if (load && legal) begin
          idx_n = sel;
          act_n = 1'b1;
        end else begin
          act_n = 1'b0;
          err_n = load;
        end
      end
      default: begin
        act_n = 1'b0;
      end
    endcase

    hot_n = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      hot_n[i] = act_n && (idx_n == SEL_W'(i));
    end
    m_n = hot_n ^ POL_MASK;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q <= MODE_OFF;
      div_q  <= '0;
      idx_q  <= '0;
      act_q  <= 1'b0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
      m_q    <= POL_MASK;
    end else if (en) begin
      mode_q <= mode_n;
      div_q  <= div_n;
      idx_q  <= idx_n;
      act_q  <= act_n;
      wrap_q <= wrap_n;
      err_q  <= err_n;
      m_q    <= m_n;
    end
  end

  assign m     = m_q;
  assign idx   = idx_q;
  assign valid = act_q;
  assign wrap  = wrap_q;
  assign err   = err_q;

endmodule

// File: tb/tb_decoder_nto2n_seq.sv
// Bench for decoder_nto2n_seq: two configurations driven in lockstep, checked
// every cycle against an abstract model plus directed tables and sequences.
module tb_decoder_nto2n_seq;

  logic       clk;
  logic       reset_n;
  logic       en;
  logic       load;
  logic [1:0] mode;
  logic [3:0] sel_a;
  logic [2:0] sel_b;
  logic [7:0] m_a;
  logic [3:0] idx_a;
  logic       valid_a, wrap_a, err_a;
  logic [4:0] m_b;
  logic [2:0] idx_b;
  logic       valid_b, wrap_b, err_b;

  int n_cmp = 0;
  int n_bad = 0;

  assign sel_b = sel_a[2:0];

  decoder_nto2n_seq #(.SEL_W(4), .NUM_OUT(8), .SCAN_DIV(2), .ACTIVE_LOW(0)) dut_a (
    .clk(clk), .reset_n(reset_n), .en(en), .mode(mode), .sel(sel_a), .load(load),
    .m(m_a), .idx(idx_a), .valid(valid_a), .wrap(wrap_a), .err(err_a)
  );

  decoder_nto2n_seq #(.SEL_W(3), .NUM_OUT(5), .SCAN_DIV(1), .ACTIVE_LOW(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .en(en), .mode(mode), .sel(sel_b), .load(load),
    .m(m_b), .idx(idx_b), .valid(valid_b), .wrap(wrap_b), .err(err_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: behavioural state of one decoder
  typedef struct {
    int idx;
    bit act;
    bit wrap;
    bit err;
    int div;
    int pmode;
  } st_t;

  st_t sa, sb;

  function automatic st_t model_step(st_t s, int n, int d, bit e, int md, bit ld, int sl);
    st_t r = s;
    bit  legal;
    bit  chg;
    if (!e) return r;
    r.wrap  = 0;
    r.err   = 0;
    legal   = (sl < n);
    chg     = (md != s.pmode);
    r.pmode = md;
    case (md)
      0: begin
        r.act = 0;
        r.div = 0;
      end
      1: begin
        r.div = 0;
        if (ld) begin
          if (legal) begin
            r.idx = sl;
            r.act = 1;
          end else begin
            r.act = 0;
            r.err = 1;
          end
        end else if (chg) begin
          r.act = 0;
        end
      end
      2: begin
        r.act = 1;
        if (ld && legal) begin
          r.idx = sl;
          r.div = 0;
        end else begin
          r.err = ld;
          if (chg) r.div = 0;
          else if (s.div == d - 1) begin
            r.div = 0;
            r.idx = (s.idx + 1) % n;
            r.wrap = (r.idx == 0);
          end else begin
            r.div = s.div + 1;
          end
        end
      end
      default: begin
        r.div = 0;
        r.act = ld && legal;
        if (ld && legal) r.idx = sl;
        r.err = ld && !legal;
      end
    endcase
    return r;
  endfunction

  function automatic logic [31:0] exp_m(st_t s, int n, bit al);
    logic [31:0] v;
    v = s.act ? (32'd1 << s.idx) : 32'd0;
    if (al) v = v ^ ((32'd1 << n) - 32'd1);
    return v;
  endfunction

  // scoreboard
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("a_m",     {24'd0, m_a},     exp_m(sa, 8, 1'b0));
    chk("a_idx",   {28'd0, idx_a},   sa.idx);
    chk("a_valid", {31'd0, valid_a}, {31'd0, sa.act});
    chk("a_wrap",  {31'd0, wrap_a},  {31'd0, sa.wrap});
    chk("a_err",   {31'd0, err_a},   {31'd0, sa.err});
    chk("b_m",     {27'd0, m_b},     exp_m(sb, 5, 1'b1));
    chk("b_idx",   {29'd0, idx_b},   sb.idx);
    chk("b_valid", {31'd0, valid_b}, {31'd0, sb.act});
    chk("b_wrap",  {31'd0, wrap_b},  {31'd0, sb.wrap});
    chk("b_err",   {31'd0, err_b},   {31'd0, sb.err});
  endtask

  // driver: apply one cycle of inputs, advance the model, compare after the edge
  task automatic cycle(input bit e, input int md, input bit ld, input int s);
    st_t na, nb;
    en    = e;
    mode  = md[1:0];
    load  = ld;
    sel_a = s[3:0];
    na = model_step(sa, 8, 2, e, md, ld, s & 15);
    nb = model_step(sb, 5, 1, e, md, ld, s & 7);
    @(posedge clk);
    #1;
    sa = na;
    sb = nb;
    check_model();
  endtask

  task automatic model_reset();
    sa = '{idx: 0, act: 0, wrap: 0, err: 0, div: 0, pmode: 0};
    sb = sa;
  endtask

  typedef struct {
    bit         e;
    int         md;
    bit         ld;
    int         s;
    logic [7:0] m;
    int         idx;
    bit         v;
    bit         w;
    bit         er;
  } vec_t;

  vec_t tbl[14];

  initial begin
    tbl[0]  = '{1, 1, 1, 5, 8'h20, 5, 1, 0, 0};
    tbl[1]  = '{1, 1, 0, 0, 8'h20, 5, 1, 0, 0};
    tbl[2]  = '{1, 1, 0, 0, 8'h20, 5, 1, 0, 0};
    tbl[3]  = '{1, 1, 0, 0, 8'h20, 5, 1, 0, 0};
    tbl[4]  = '{1, 1, 1, 9, 8'h00, 5, 0, 0, 1};
    tbl[5]  = '{1, 1, 0, 0, 8'h00, 5, 0, 0, 0};
    tbl[6]  = '{1, 1, 1, 0, 8'h01, 0, 1, 0, 0};
    tbl[7]  = '{1, 3, 1, 2, 8'h04, 2, 1, 0, 0};
    tbl[8]  = '{1, 3, 1, 2, 8'h04, 2, 1, 0, 0};
    tbl[9]  = '{1, 3, 0, 0, 8'h00, 2, 0, 0, 0};
    tbl[10] = '{1, 3, 1, 6, 8'h40, 6, 1, 0, 0};
    tbl[11] = '{1, 3, 0, 0, 8'h00, 6, 0, 0, 0};
    tbl[12] = '{1, 3, 1, 8, 8'h00, 6, 0, 0, 1};
    tbl[13] = '{1, 0, 1, 3, 8'h00, 6, 0, 0, 0};

    reset_n = 1'b0;
    en      = 1'b0;
    mode    = 2'b00;
    load    = 1'b0;
    sel_a   = 4'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk("rst_m_a",   {24'd0, m_a},     32'h00);
    chk("rst_idx_a", {28'd0, idx_a},   32'd0);
    chk("rst_val_a", {31'd0, valid_a}, 32'd0);
    chk("rst_wrap",  {31'd0, wrap_a},  32'd0);
    chk("rst_err",   {31'd0, err_a},   32'd0);
    chk("rst_m_b",   {27'd0, m_b},     32'h1f);
    check_model();

    // directed DIRECT / STROBE / OFF table
    for (int i = 0; i < 14; i++) begin
      cycle(tbl[i].e, tbl[i].md, tbl[i].ld, tbl[i].s);
      chk($sformatf("tbl%0d_m", i),   {24'd0, m_a},     {24'd0, tbl[i].m});
      chk($sformatf("tbl%0d_idx", i), {28'd0, idx_a},   tbl[i].idx);
      chk($sformatf("tbl%0d_v", i),   {31'd0, valid_a}, {31'd0, tbl[i].v});
      chk($sformatf("tbl%0d_w", i),   {31'd0, wrap_a},  {31'd0, tbl[i].w});
      chk($sformatf("tbl%0d_e", i),   {31'd0, err_a},   {31'd0, tbl[i].er});
    end

    // SCAN from idx 0: entry edge, then one step every two edges, wrap on 7->0
    cycle(1, 1, 1, 0);
    cycle(1, 2, 0, 0);
    for (int k = 1; k <= 16; k++) begin
      cycle(1, 2, 0, 0);
      chk($sformatf("scan%0d_idx", k), {28'd0, idx_a},  (k / 2) % 8);
      chk($sformatf("scan%0d_wrap", k), {31'd0, wrap_a}, (k == 16) ? 32'd1 : 32'd0);
    end

    // en low freezes everything
    for (int k = 0; k < 3; k++) begin
      cycle(0, 2, 1, 5);
      chk("frz_idx", {28'd0, idx_a}, 32'd0);
      chk("frz_m",   {24'd0, m_a},   32'h01);
    end

    // load collides with the divider's last count: load wins, no wrap
    cycle(1, 2, 0, 0);
    cycle(1, 2, 1, 3);
    chk("col_idx",  {28'd0, idx_a},  32'd3);
    chk("col_wrap", {31'd0, wrap_a}, 32'd0);
    cycle(1, 2, 0, 0);
    chk("col_hold", {28'd0, idx_a}, 32'd3);
    cycle(1, 2, 0, 0);
    chk("col_step", {28'd0, idx_a}, 32'd4);

    // asynchronous reset mid-scan, checked before the next clock edge
    #1;
    reset_n = 1'b0;
    #2;
    chk("arst_m_a",   {24'd0, m_a},     32'h00);
    chk("arst_idx_a", {28'd0, idx_a},   32'd0);
    chk("arst_val_a", {31'd0, valid_a}, 32'd0);
    chk("arst_m_b",   {27'd0, m_b},     32'h1f);
    chk("arst_idx_b", {29'd0, idx_b},   32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();

    // randomized stimulus with sticky modes so scans run for a while
    begin
      int md = 2;
      for (int k = 0; k < 800; k++) begin
        if ($urandom_range(0, 7) == 0) md = $urandom_range(0, 3);
        cycle($urandom_range(0, 9) != 0, md, $urandom_range(0, 3) == 0,
              $urandom_range(0, 15));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
